alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_muldiv.sv | 82 ++++++++
 rtl/alu_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_OR   = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_NOR  = 4'd5;
    localparam logic [3:0] FN_SLL  = 4'd6;
    localparam logic [3:0] FN_SRL  = 4'd7;
    localparam logic [3:0] FN_SRA  = 4'd8;
    localparam logic [3:0] FN_SLT  = 4'd9;
    localparam logic [3:0] FN_SLTU = 4'd10;
    localparam logic [3:0] FN_MUL  = 4'd11;
    localparam logic [3:0] FN_DIVU = 4'd12;
    localparam logic [3:0] FN_REMU = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic is_iter(input logic [3:0] f);
        return (f == FN_MUL) || (f == FN_DIVU) || (f == FN_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiply and restoring divide, one bit per cycle.
// done pulses for one cycle after exactly WIDTH iterations.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic             busy_reg, done_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [3:0]       func_reg;
    // acc: product accumulator or partial remainder; x: multiplicand or dividend/quotient
    logic [WIDTH-1:0] acc_reg, x_reg, y_reg;
    logic [WIDTH-1:0] acc_next, x_next, y_next;
    logic [WIDTH:0]   rem_sh, diff;

    assign rem_sh = {acc_reg, x_reg[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, y_reg};

    always_comb begin
        acc_next = acc_reg;
        x_next   = x_reg;
        y_next   = y_reg;
        if (func_reg == FN_MUL) begin
            acc_next = y_reg[0] ? (acc_reg + x_reg) : acc_reg;
            x_next   = x_reg << 1;
            y_next   = y_reg >> 1;
        end else if (!diff[WIDTH]) begin
            acc_next = diff[WIDTH-1:0];
            x_next   = {x_reg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = rem_sh[WIDTH-1:0];
            x_next   = {x_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            cnt_reg  <= '0;
            func_reg <= FN_MUL;
            acc_reg  <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                busy_reg <= 1'b1;
                cnt_reg  <= '0;
                func_reg <= func;
                acc_reg  <= '0;
                x_reg    <= a;
                y_reg    <= b;
            end else if (busy_reg) begin
                acc_reg <= acc_next;
                x_reg   <= x_next;
                y_reg   <= y_next;
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done   = done_reg;
    assign result = (func_reg == FN_DIVU) ? x_reg : acc_reg;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops go straight to the result register,
// MUL/DIVU/REMU run through alu_muldiv for WIDTH cycles.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zero,
    output logic             ovf,
    output logic             err
);
    state_t           state_reg, state_next;
    logic [WIDTH-1:0] o_reg;
    logic             zero_reg, ovf_reg, err_reg;
    logic             accept, iter, md_done;
    logic [WIDTH-1:0] md_result, sum, dif, alu_o;
    logic             alu_ovf, alu_err;

    assign iter      = is_iter(func);
    assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready);
    assign out_valid = (state_reg == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign sum       = i1 + i2;
    assign dif       = i1 - i2;

    always_comb begin
        alu_o   = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (func)
            FN_ADD: begin
                alu_o   = sum;
                alu_ovf = (i1[WIDTH-1] == i2[WIDTH-1]) && (sum[WIDTH-1] != i1[WIDTH-1]);
            end
            FN_SUB: begin
                alu_o   = dif;
                alu_ovf = (i1[WIDTH-1] != i2[WIDTH-1]) && (dif[WIDTH-1] != i1[WIDTH-1]);
            end
            FN_AND:  alu_o = i1 & i2;
            FN_OR:   alu_o = i1 | i2;
            FN_XOR:  alu_o = i1 ^ i2;
            FN_NOR:  alu_o = ~(i1 | i2);
            FN_SLL:  alu_o = i1 << shamt;
            FN_SRL:  alu_o = i1 >> shamt;
            FN_SRA:  alu_o = $signed(i1) >>> shamt;
            FN_SLT:  alu_o = {{(WIDTH-1){1'b0}}, $signed(i1) < $signed(i2)};
            FN_SLTU: alu_o = {{(WIDTH-1){1'b0}}, i1 < i2};
            FN_MUL, FN_DIVU, FN_REMU: alu_o = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = iter ? ST_BUSY : ST_HOLD;
            ST_BUSY: if (md_done) state_next = ST_HOLD;
            ST_HOLD: begin
                if (accept)         state_next = iter ? ST_BUSY : ST_HOLD;
                else if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            o_reg     <= '0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && !iter) begin
                o_reg    <= alu_o;
                zero_reg <= (alu_o == '0);
                ovf_reg  <= alu_ovf;
                err_reg  <= alu_err;
            end else if ((state_reg == ST_BUSY) && md_done) begin
                o_reg    <= md_result;
                zero_reg <= (md_result == '0);
                ovf_reg  <= 1'b0;
                err_reg  <= 1'b0;
            end
        end
    end

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && iter),
        .func   (func),
        .a      (i1),
        .b      (i2),
        .done   (md_done),
        .result (md_result)
    );

    assign o    = o_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;
    assign err  = err_reg;

endmodule
